pipe_front_regs: RTL and testbench

- Holds the PC, the IF/ID register and the ID/EX register for the 5-stage pipeline.
- Supplies d_instr, x_rt and x_M to the hazard detection unit and consumes its haz_pcEn, haz_ifidEn and haz_idexEn to stall, hold or bubble.
- Applies branch flushes, latches a sticky halted flag after a halt instruction drains, and counts stall cycles for the perf counters.

---
 rtl/pipe_front_regs_if.sv | 46 ++++
 rtl/pipe_front_regs.sv | 100 ++++++++++
 tb/tb_pipe_front_regs.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_front_regs_if.sv
// Bundle between the front-end register block and the rest of the 5-stage pipeline.
// The pipeline side is the master; the register block is the slave.
interface pipe_front_regs_if;
    // Fetch, hazard unit, branch resolution and decode inputs
    logic [31:0] f_instr;
    logic        haz_pcEn;
    logic        haz_ifidEn;
    logic        haz_idexEn;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  d_WB;
    logic [2:0]  d_M;
    logic [3:0]  d_EX;
    logic [31:0] d_rs_data;
    logic [31:0] d_rt_data;

    // Register state seen by fetch, decode, hazard unit and EX
    logic [31:0] pc;
    logic [31:0] d_instr;
    logic [31:0] d_pcplus4;
    logic [1:0]  x_WB;
    logic [2:0]  x_M;
    logic [3:0]  x_EX;
    logic [4:0]  x_rs;
    logic [4:0]  x_rt;
    logic [4:0]  x_rd;
    logic [31:0] x_rs_data;
    logic [31:0] x_rt_data;
    logic [31:0] x_imm;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output f_instr, haz_pcEn, haz_ifidEn, haz_idexEn, branch_taken, branch_target,
               d_WB, d_M, d_EX, d_rs_data, d_rt_data,
        input  pc, d_instr, d_pcplus4, x_WB, x_M, x_EX, x_rs, x_rt, x_rd,
               x_rs_data, x_rt_data, x_imm, halted, stall_count
    );

    modport slave (
        input  f_instr, haz_pcEn, haz_ifidEn, haz_idexEn, branch_taken, branch_target,
               d_WB, d_M, d_EX, d_rs_data, d_rt_data,
        output pc, d_instr, d_pcplus4, x_WB, x_M, x_EX, x_rs, x_rt, x_rd,
               x_rs_data, x_rt_data, x_imm, halted, stall_count
    );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with branch flush, hazard stall/bubble,
// sticky halt detection after a drain period, and a saturating stall counter.
module pipe_front_regs #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP   = 6'h3f,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              reset,
    pipe_front_regs_if.slave  bus
);

    localparam int CNT_W = $clog2(DRAIN_CYC + 1);

    logic [CNT_W-1:0] drain_cnt;
    logic [31:0]      pc_plus4;
    logic             halt_in_decode;
    logic             bubble;

    assign pc_plus4       = bus.pc + 32'd4;
    assign halt_in_decode = (bus.d_instr[31:26] == HALT_OP) && !bus.branch_taken;
    // A taken branch in EX is older than whatever decode is stalling on, so it wins.
    assign bubble         = bus.branch_taken || bus.haz_idexEn;

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of its peers, exactly like the flops they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc <= PC_RESET;
        end else if (bus.halted) begin
            bus.pc <= bus.pc;
        end else if (bus.branch_taken) begin
            bus.pc <= bus.branch_target;
        end else if (bus.haz_pcEn) begin
            bus.pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.branch_taken) begin
            bus.d_instr   <= '0;
            bus.d_pcplus4 <= '0;
        end else if (bus.haz_ifidEn) begin
            bus.d_instr   <= bus.f_instr;
            bus.d_pcplus4 <= pc_plus4;
        end
    end

    // A bubble clears x_M[1] as well, so it can never look like a pending load.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            bus.x_WB      <= '0;
            bus.x_M       <= '0;
            bus.x_EX      <= '0;
            bus.x_rs      <= '0;
            bus.x_rt      <= '0;
            bus.x_rd      <= '0;
            bus.x_rs_data <= '0;
            bus.x_rt_data <= '0;
            bus.x_imm     <= '0;
        end else begin
            bus.x_WB      <= bus.d_WB;
            bus.x_M       <= bus.d_M;
            bus.x_EX      <= bus.d_EX;
            bus.x_rs      <= bus.d_instr[25:21];
            bus.x_rt      <= bus.d_instr[20:16];
            bus.x_rd      <= bus.d_instr[15:11];
            bus.x_rs_data <= bus.d_rs_data;
            bus.x_rt_data <= bus.d_rt_data;
            bus.x_imm     <= {{16{bus.d_instr[15]}}, bus.d_instr[15:0]};
        end
    end

    // halted rises on the edge where the halt has sat in decode for DRAIN_CYC cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt  <= '0;
            bus.halted <= 1'b0;
        end else if (halt_in_decode) begin
            if (drain_cnt == CNT_W'(DRAIN_CYC - 1)) begin
                bus.halted <= 1'b1;
            end
            if (drain_cnt != CNT_W'(DRAIN_CYC)) begin
                drain_cnt <= drain_cnt + CNT_W'(1);
            end
        end else begin
            drain_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stall_count <= '0;
        end else if (!bus.haz_pcEn && !bus.branch_taken && !bus.halted
                     && (bus.stall_count != 16'hFFFF)) begin
            bus.stall_count <= bus.stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: directed scenarios plus randomized
// traffic, all compared each cycle against a behavioural reference model.
module tb_pipe_front_regs;

    localparam logic [5:0] HALT_OP   = 6'h3f;
    localparam int         DRAIN_CYC = 3;
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_front_regs_if bus ();

    pipe_front_regs #(
        .PC_RESET (32'h0000_0000),
        .HALT_OP  (HALT_OP),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc, m_di, m_dp4, m_xrs_data, m_xrt_data, m_ximm;
    logic [1:0]  m_xwb;
    logic [2:0]  m_xm;
    logic [3:0]  m_xex;
    logic [4:0]  m_xrs, m_xrt, m_xrd;
    logic        m_halted;
    logic [15:0] m_stall;
    int          m_drain;

    // Advance the model by one clock edge from the inputs currently applied.
    task automatic model_step();
        logic [31:0] pc_old;
        logic [31:0] di_old;
        pc_old = m_pc;
        di_old = m_di;
        if (reset) begin
            m_pc = 32'h0; m_di = 32'h0; m_dp4 = 32'h0;
            m_xwb = '0; m_xm = '0; m_xex = '0; m_xrs = '0; m_xrt = '0; m_xrd = '0;
            m_xrs_data = '0; m_xrt_data = '0; m_ximm = '0;
            m_halted = 1'b0; m_stall = '0; m_drain = 0;
        end else begin
            if (!bus.haz_pcEn && !bus.branch_taken && !m_halted && m_stall != 16'hFFFF)
                m_stall = m_stall + 16'd1;

            if (m_halted) m_pc = pc_old;
            else if (bus.branch_taken) m_pc = bus.branch_target;
            else if (bus.haz_pcEn) m_pc = pc_old + 32'd4;

            if (di_old[31:26] == HALT_OP && !bus.branch_taken) m_drain = m_drain + 1;
            else m_drain = 0;
            if (m_drain >= DRAIN_CYC) m_halted = 1'b1;

            if (bus.branch_taken) begin
                m_di = 32'h0; m_dp4 = 32'h0;
            end else if (bus.haz_ifidEn) begin
                m_di = bus.f_instr; m_dp4 = pc_old + 32'd4;
            end

            if (bus.branch_taken || bus.haz_idexEn) begin
                m_xwb = '0; m_xm = '0; m_xex = '0; m_xrs = '0; m_xrt = '0; m_xrd = '0;
                m_xrs_data = '0; m_xrt_data = '0; m_ximm = '0;
            end else begin
                m_xwb = bus.d_WB; m_xm = bus.d_M; m_xex = bus.d_EX;
                m_xrs = di_old[25:21]; m_xrt = di_old[20:16]; m_xrd = di_old[15:11];
                m_xrs_data = bus.d_rs_data; m_xrt_data = bus.d_rt_data;
                m_ximm = 32'($signed(di_old[15:0]));
            end
        end
    endtask

    task automatic compare_all();
        check("pc",          bus.pc,                 m_pc);
        check("d_instr",     bus.d_instr,            m_di);
        check("d_pcplus4",   bus.d_pcplus4,          m_dp4);
        check("x_WB",        32'(bus.x_WB),          32'(m_xwb));
        check("x_M",         32'(bus.x_M),           32'(m_xm));
        check("x_EX",        32'(bus.x_EX),          32'(m_xex));
        check("x_rs",        32'(bus.x_rs),          32'(m_xrs));
        check("x_rt",        32'(bus.x_rt),          32'(m_xrt));
        check("x_rd",        32'(bus.x_rd),          32'(m_xrd));
        check("x_rs_data",   bus.x_rs_data,          m_xrs_data);
        check("x_rt_data",   bus.x_rt_data,          m_xrt_data);
        check("x_imm",       bus.x_imm,              m_ximm);
        check("halted",      32'(bus.halted),        32'(m_halted));
        check("stall_count", 32'(bus.stall_count),   32'(m_stall));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_haz(input logic pc_en, input logic ifid_en, input logic idex_en,
                           input logic br, input logic [31:0] target);
        bus.haz_pcEn      = pc_en;
        bus.haz_ifidEn    = ifid_en;
        bus.haz_idexEn    = idex_en;
        bus.branch_taken  = br;
        bus.branch_target = target;
    endtask

    task automatic rand_decode();
        bus.d_WB      = 2'($urandom);
        bus.d_M       = 3'($urandom);
        bus.d_EX      = 4'($urandom);
        bus.d_rs_data = $urandom;
        bus.d_rt_data = $urandom;
    endtask

    logic [31:0] saved_pc, saved_di;
    logic [15:0] saved_stall;

    initial begin
        reset = 1'b1;
        bus.f_instr = 32'h0;
        set_haz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rand_decode();
        tick();
        tick();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        reset = 1'b0;

        // Straight-line fetch
        for (int i = 0; i < 4; i++) begin
            bus.f_instr = 32'h1000_0000 + 32'(i * 32'h0001_2345);
            set_haz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            rand_decode();
            tick();
            check("t1_pc", bus.pc, 32'(4 * (i + 1)));
            check("t1_d_instr", bus.d_instr, 32'h1000_0000 + 32'(i * 32'h0001_2345));
        end

        // Load-use stall with a bubble into EX
        saved_pc = bus.pc;
        saved_di = bus.d_instr;
        bus.f_instr = 32'h2222_8888;
        set_haz(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.d_M = 3'b010;
        tick();
        check("t2_pc_hold", bus.pc, saved_pc);
        check("t2_di_hold", bus.d_instr, saved_di);
        check("t2_x_M", 32'(bus.x_M), 32'h0);
        check("t2_x_rt", 32'(bus.x_rt), 32'h0);
        check("t2_stall", 32'(bus.stall_count), 32'd1);
        set_haz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        rand_decode();
        tick();
        check("t2_pc_resume", bus.pc, saved_pc + 32'd4);
        check("t2_x_rt_resume", 32'(bus.x_rt), 32'(saved_di[20:16]));
        check("t2_di_resume", bus.d_instr, 32'h2222_8888);

        // Branch overrides a simultaneous stall/bubble request
        set_haz(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        tick();
        check("t3_pc", bus.pc, 32'h0000_0100);
        check("t3_d_instr", bus.d_instr, 32'h0);
        check("t3_x_M", 32'(bus.x_M), 32'h0);
        check("t3_stall", 32'(bus.stall_count), 32'd1);

        // Halt drains for DRAIN_CYC cycles then sticks
        bus.f_instr = HALT_INSTR;
        set_haz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        set_haz(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        check("t4_halted_early", 32'(bus.halted), 32'h0);
        tick();
        check("t4_halted", 32'(bus.halted), 32'h1);
        saved_pc = bus.pc;
        saved_stall = bus.stall_count;
        set_haz(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t4_pc_frozen", bus.pc, saved_pc);
        set_haz(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
        tick();
        check("t4_halted_br", 32'(bus.halted), 32'h1);
        check("t4_pc_br", bus.pc, saved_pc);
        check("t4_stall_frozen", 32'(bus.stall_count), 32'(saved_stall));
        reset = 1'b1;
        tick();
        check("t4_halted_rst", 32'(bus.halted), 32'h0);
        reset = 1'b0;

        // Halt flushed by a branch before it drains
        bus.f_instr = HALT_INSTR;
        set_haz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        set_haz(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        set_haz(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        set_haz(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_halted", 32'(bus.halted), 32'h0);
        check("t5_pc", bus.pc, 32'h0000_0040);

        // Stall counter saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_haz(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.f_instr = 32'h0;
        for (int i = 0; i < 65537; i++) tick();
        check("t6_sat", 32'(bus.stall_count), 32'h0000_FFFF);

        // PC wrap
        set_haz(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        set_haz(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.f_instr = 32'h1234_5678;
        tick();
        check("t6_wrap_pc", bus.pc, 32'h0);
        check("t6_wrap_pcplus4", bus.d_pcplus4, 32'h0);

        // Reset asserted mid-stall
        set_haz(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_stall", 32'(bus.stall_count), 32'h0);
        check("t6_rst_pc", bus.pc, 32'h0);
        check("t6_rst_di", bus.d_instr, 32'h0);
        reset = 1'b0;

        // Randomized traffic in segments separated by reset
        for (int seg = 0; seg < 8; seg++) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int i = 0; i < 250; i++) begin
                set_haz(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                        ($urandom % 8) == 0, $urandom & 32'hFFFF_FFFC);
                bus.f_instr = (($urandom % 5) == 0) ? (HALT_INSTR | ($urandom & 32'h03FF_FFFF))
                                                   : ($urandom & 32'hF7FF_FFFF);
                rand_decode();
                reset = (($urandom % 120) == 0);
                tick();
            end
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
